increment_5bit: RTL and testbench
=================================

Name: increment_5bit

Overview:
- Fixed-step +1 incrementer for the datapath: combinational increment of a WIDTH-bit operand, modulo 2^WIDTH.
- Also provides a registered copy of the result with valid, carry and a wrap-event counter, so downstream stages can use either the combinational or the pipelined result.

Parameters:
- WIDTH, 5, operand/result width in bits (minimum 1).
- WRAP_CNT_W, 8, width of the wrap-event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  WIDTH  operand.
- in_valid  input  1  qualifies data_in for the registered path.
- wrap_clr  input  1  synchronous clear of wrap_cnt.
- data_out  output  WIDTH  combinational data_in + 1, truncated to WIDTH.
- carry_out  output  1  combinational; 1 when data_in == all-ones.
- q_out  output  WIDTH  registered result.
- q_valid  output  1  registered in_valid.
- q_carry  output  1  registered carry_out.
- wrap_cnt  output  WRAP_CNT_W  count of accepted wrap events.

Behaviour:
- Reset is asynchronous and active-low: rst_n low immediately forces q_out=0, q_valid=0, q_carry=0, wrap_cnt=0, independent of clk.
- Release of rst_n is sampled on the next rising clk edge; the first update is at the first edge with rst_n high.
- Combinational path:
  - data_out = (data_in + 1) mod 2^WIDTH, carry_out = (data_in == 2^WIDTH-1).
  - Zero latency; unaffected by clk, rst_n and in_valid.
  - For WIDTH=5: 0->1, 1->2, 23->24, 30->31, 31->0 with carry_out=1.
- Registered path, updates on each rising clk edge when rst_n is high:
  - q_valid <= in_valid every cycle.
  - When in_valid=1: q_out <= data_out and q_carry <= carry_out.
  - When in_valid=0: q_out and q_carry hold their previous values.
  - Latency is 1 cycle; throughput is one operand per cycle; there is no backpressure.
- wrap_cnt:
  - Increments by 1 on an edge where in_valid=1 and carry_out=1.
  - Saturates at all-ones and never wraps.
  - wrap_clr=1 sets it to 0 on the edge; wrap_clr has priority over a simultaneous increment.
- Reset asserted mid-stream discards any in-flight result; q_valid is 0 until the next accepted operand.
- Outputs never take X/Z once rst_n has been asserted, assuming inputs are known.
- Purely unsigned arithmetic; no overflow exception beyond carry.

Optional Feature:
- Macro INC_SATURATE_EN.
- Defined: saturating mode.
  - data_in == all-ones gives data_out = all-ones (31 stays 31), carry_out=1 as a saturation flag.
  - wrap_cnt counts saturation events; all other values increment normally.
- Undefined (default): modulo wrap as described above (31 -> 0).

Test Plan:
- Combinational sweep, WIDTH=5, 10 time units per step: data_in 0, 1, 23, 31 -> data_out 1, 2, 24, 0; carry_out 0, 0, 0, 1.
- Registered path: in_valid=1, data_in=23 at edge N -> at N+1 q_out=24, q_valid=1, q_carry=0. Then in_valid=0 -> q_out stays 24, q_valid=0.
- Wrap counting: three valid cycles of data_in=31, then wrap_clr=1 with data_in=31 valid -> wrap_cnt 1, 2, 3 then 0 (clear wins).
- Asynchronous reset: assert rst_n=0 between edges while q_out=24 -> q_out, q_valid, q_carry, wrap_cnt read 0 immediately, without waiting for a clock edge.
- Exhaustive check: all 32 values, in_valid=1 -> q_out equals (x+1) mod 32 one cycle later; q_carry=1 only for x=31.
- With INC_SATURATE_EN defined: data_in=31 -> data_out=31, carry_out=1; data_in=30 -> data_out=31, carry_out=0.

Source files
------------

// File: rtl/increment_5bit.sv
// Fixed-step +1 incrementer: combinational result plus a registered copy with valid, carry and a wrap-event counter.
// Optional INC_SATURATE_EN makes the all-ones operand saturate instead of wrapping to zero.
module increment_5bit #(
   parameter int WIDTH      = 5,
   parameter int WRAP_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH-1:0]      data_in,
   input  logic                  in_valid,
   input  logic                  wrap_clr,
   output logic [WIDTH-1:0]      data_out,
   output logic                  carry_out,
   output logic [WIDTH-1:0]      q_out,
   output logic                  q_valid,
   output logic                  q_carry,
   output logic [WRAP_CNT_W-1:0] wrap_cnt
);

   localparam logic [WIDTH-1:0]      ALL_ONES = '1;
   localparam logic [WRAP_CNT_W-1:0] CNT_MAX  = '1;

   logic [WIDTH-1:0]      q_out_d, q_out_q;
   logic                  q_valid_d, q_valid_q;
   logic                  q_carry_d, q_carry_q;
   logic [WRAP_CNT_W-1:0] wrap_cnt_d, wrap_cnt_q;

   always_comb begin
      carry_out = (data_in == ALL_ONES);
`ifdef INC_SATURATE_EN
      data_out  = carry_out ? ALL_ONES : data_in + WIDTH'(1);
`else
      data_out  = data_in + WIDTH'(1);
`endif
   end

   always_comb begin
      q_valid_d  = in_valid;
      q_out_d    = q_out_q;
      q_carry_d  = q_carry_q;
      wrap_cnt_d = wrap_cnt_q;
      if (in_valid) begin
         q_out_d   = data_out;
         q_carry_d = carry_out;
      end
      // clear outranks a same-cycle wrap event; the counter sticks at its maximum
      if (wrap_clr) begin
         wrap_cnt_d = '0;
      end else if (in_valid && carry_out && (wrap_cnt_q != CNT_MAX)) begin
         wrap_cnt_d = wrap_cnt_q + WRAP_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_out_q    <= '0;
         q_valid_q  <= 1'b0;
         q_carry_q  <= 1'b0;
         wrap_cnt_q <= '0;
      end else begin
         q_out_q    <= q_out_d;
         q_valid_q  <= q_valid_d;
         q_carry_q  <= q_carry_d;
         wrap_cnt_q <= wrap_cnt_d;
      end
   end

   assign q_out    = q_out_q;
   assign q_valid  = q_valid_q;
   assign q_carry  = q_carry_q;
   assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_increment_5bit.sv
// Scoreboard bench for increment_5bit: stimulus pushes expected registered results, a monitor pops on q_valid.
module tb_increment_5bit;

   logic       clk;
   logic       rst_n;
   logic [4:0] data_in;
   logic       in_valid;
   logic       wrap_clr;
   logic [4:0] data_out;
   logic       carry_out;
   logic [4:0] q_out;
   logic       q_valid;
   logic       q_carry;
   logic [7:0] wrap_cnt;

   typedef struct packed {
      logic [4:0] q;
      logic       c;
      logic [7:0] w;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   model_wrap = 0;

   increment_5bit #(.WIDTH(5), .WRAP_CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_in   (data_in),
      .in_valid  (in_valid),
      .wrap_clr  (wrap_clr),
      .data_out  (data_out),
      .carry_out (carry_out),
      .q_out     (q_out),
      .q_valid   (q_valid),
      .q_carry   (q_carry),
      .wrap_cnt  (wrap_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else
         n_pass++;
   endtask

   function automatic logic [5:0] inc_model(input logic [4:0] x);
      logic [4:0] r;
`ifdef INC_SATURATE_EN
      r = (x == 5'd31) ? 5'd31 : x + 5'd1;
`else
      r = x + 5'd1;
`endif
      return {(x == 5'd31), r};
   endfunction

   // drive one cycle of stimulus just after the rising edge and record what it should produce
   task automatic step(input logic v, input logic [4:0] x, input logic clr);
      logic [5:0] m;
      exp_t e;
      @(posedge clk);
      #1;
      in_valid = v;
      data_in  = x;
      wrap_clr = clr;
      m = inc_model(x);
      if (clr)
         model_wrap = 0;
      else if (v && x == 5'd31 && model_wrap < 255)
         model_wrap++;
      if (v) begin
         e.q = m[4:0];
         e.c = m[5];
         e.w = 8'(model_wrap);
         sb.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && q_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL sb_unexpected: q_valid=1 with q_out=%0d, expected no output", q_out);
         end else begin
            e = sb.pop_front();
            check("sb_q_out", 32'(q_out), 32'(e.q));
            check("sb_q_carry", 32'(q_carry), 32'(e.c));
            check("sb_wrap_cnt", 32'(wrap_cnt), 32'(e.w));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   logic [4:0] comb_in  [5] = '{5'd0, 5'd1, 5'd23, 5'd30, 5'd31};
   logic [4:0] comb_exp [5] = '{5'd1, 5'd2, 5'd24, 5'd31, 5'd0};
   logic       comb_cy  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      rst_n    = 1'b0;
      data_in  = '0;
      in_valid = 1'b0;
      wrap_clr = 1'b0;
      #3;
      check("rst_q_out", 32'(q_out), 0);
      check("rst_q_valid", 32'(q_valid), 0);
      check("rst_q_carry", 32'(q_carry), 0);
      check("rst_wrap_cnt", 32'(wrap_cnt), 0);

      // combinational path is live even while the registers are held in reset
      for (int i = 0; i < 5; i++) begin
         logic [4:0] e;
         e = comb_exp[i];
`ifdef INC_SATURATE_EN
         if (comb_in[i] == 5'd31) e = 5'd31;
`endif
         data_in = comb_in[i];
         #10;
         check("comb_data_out", 32'(data_out), 32'(e));
         check("comb_carry_out", 32'(carry_out), 32'(comb_cy[i]));
      end
      check("rst_hold_q_valid", 32'(q_valid), 0);

      @(negedge clk);
      rst_n = 1'b1;

      step(1'b1, 5'd23, 1'b0);
      step(1'b0, 5'd5, 1'b0);
      @(posedge clk);
      #2;
      check("hold_q_valid", 32'(q_valid), 0);
      check("hold_q_out", 32'(q_out), 24);
      check("hold_q_carry", 32'(q_carry), 0);

      #2;
      rst_n = 1'b0;
      #1;
      check("arst_q_out", 32'(q_out), 0);
      check("arst_q_valid", 32'(q_valid), 0);
      check("arst_q_carry", 32'(q_carry), 0);
      check("arst_wrap_cnt", 32'(wrap_cnt), 0);
      sb.delete();
      model_wrap = 0;
      @(negedge clk);
      rst_n = 1'b1;

      step(1'b1, 5'd31, 1'b0);
      step(1'b1, 5'd31, 1'b0);
      step(1'b1, 5'd31, 1'b0);
      step(1'b1, 5'd31, 1'b1);

      // long run of wrap events drives the counter into saturation
      for (int i = 0; i < 260; i++)
         step(1'b1, 5'd31, 1'b0);
      step(1'b0, 5'd31, 1'b1);

      for (int x = 0; x < 32; x++) begin
         step(1'b1, 5'(x), 1'b0);
         if (x % 5 == 4)
            step(1'b0, 5'(31 - x), 1'b0);
      end

      step(1'b0, 5'd0, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      check("sb_drained", 32'(sb.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
